parity_appender: RTL and testbench



---
 rtl/parity_appender.sv | 83 ++++++++
 tb/tb_parity_appender.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_appender.sv
// parity_appender: forwards AXI-Stream byte packets and appends
// one trailing parity byte so the emitted packet meets ODD_PARITY.
module parity_appender #(
    parameter bit ODD_PARITY = 1'b0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 in_clock,
    input  logic                 in_reset_n,
    input  logic                 axis_s_tvalid,
    input  logic [7:0]           axis_s_tdata,
    output logic                 axis_s_tready,
    input  logic                 axis_s_tlast,
    output logic                 axis_m_tvalid,
    output logic [7:0]           axis_m_tdata,
    input  logic                 axis_m_tready,
    output logic                 axis_m_tlast,
    output logic [CNT_WIDTH-1:0] pkt_count
);

    typedef enum logic {
        PASS,
        PARITY
    } state_t;

    state_t state;
    logic   acc;
    logic   par_bit;
    logic   slot_free;
    logic   s_fire;
    logic   m_fire;
    logic   byte_par;
    logic   next_acc;

    assign slot_free     = !axis_m_tvalid || axis_m_tready;
    assign axis_s_tready = (state == PASS) && slot_free;
    assign s_fire        = axis_s_tvalid && axis_s_tready;
    assign m_fire        = axis_m_tvalid && axis_m_tready;
    assign byte_par      = ^axis_s_tdata;
    assign next_acc      = acc ^ byte_par;

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state         <= PASS;
            acc           <= 1'b0;
            par_bit       <= 1'b0;
            axis_m_tvalid <= 1'b0;
            axis_m_tdata  <= 8'h00;
            axis_m_tlast  <= 1'b0;
            pkt_count     <= '0;
        end else begin
            if (m_fire && axis_m_tlast)
                pkt_count <= pkt_count + CNT_WIDTH'(1);

            unique case (state)
                PASS: begin
                    if (s_fire) begin
                        axis_m_tdata  <= axis_s_tdata;
                        axis_m_tvalid <= 1'b1;
                        axis_m_tlast  <= 1'b0;
                        acc           <= next_acc;
                        if (axis_s_tlast) begin
                            par_bit <= next_acc ^ ODD_PARITY;
                            state   <= PARITY;
                        end
                    end else if (axis_m_tready) begin
                        axis_m_tvalid <= 1'b0;
                    end
                end
                PARITY: begin
                    // Parity byte waits here until the output slot opens.
                    if (slot_free) begin
                        axis_m_tdata  <= {7'b0, par_bit};
                        axis_m_tvalid <= 1'b1;
                        axis_m_tlast  <= 1'b1;
                        acc           <= 1'b0;
                        state         <= PASS;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_appender.sv
// Directed bench for parity_appender: even, odd and narrow-counter
// instances share one stimulus stream.
module tb_parity_appender;

    logic       clk;
    logic       rst_n;
    logic       s_tvalid;
    logic [7:0] s_tdata;
    logic       s_tlast;
    logic       m_tready;

    logic        s_tready0, m_tvalid0, m_tlast0;
    logic [7:0]  m_tdata0;
    logic [15:0] cnt0;
    logic        s_tready1, m_tvalid1, m_tlast1;
    logic [7:0]  m_tdata1;
    logic [15:0] cnt1;
    logic        s_tready2, m_tvalid2, m_tlast2;
    logic [7:0]  m_tdata2;
    logic [1:0]  cnt2;

    int checks   = 0;
    int failures = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic       toggle_en  = 0;
    logic       chk_stable = 0;
    logic       stall_v    = 0;
    logic [8:0] stall_beat;

    parity_appender #(.ODD_PARITY(1'b0), .CNT_WIDTH(16)) dut0 (
        .in_clock(clk), .in_reset_n(rst_n),
        .axis_s_tvalid(s_tvalid), .axis_s_tdata(s_tdata),
        .axis_s_tready(s_tready0), .axis_s_tlast(s_tlast),
        .axis_m_tvalid(m_tvalid0), .axis_m_tdata(m_tdata0),
        .axis_m_tready(m_tready), .axis_m_tlast(m_tlast0),
        .pkt_count(cnt0)
    );

    parity_appender #(.ODD_PARITY(1'b1), .CNT_WIDTH(16)) dut1 (
        .in_clock(clk), .in_reset_n(rst_n),
        .axis_s_tvalid(s_tvalid), .axis_s_tdata(s_tdata),
        .axis_s_tready(s_tready1), .axis_s_tlast(s_tlast),
        .axis_m_tvalid(m_tvalid1), .axis_m_tdata(m_tdata1),
        .axis_m_tready(m_tready), .axis_m_tlast(m_tlast1),
        .pkt_count(cnt1)
    );

    parity_appender #(.ODD_PARITY(1'b0), .CNT_WIDTH(2)) dut2 (
        .in_clock(clk), .in_reset_n(rst_n),
        .axis_s_tvalid(s_tvalid), .axis_s_tdata(s_tdata),
        .axis_s_tready(s_tready2), .axis_s_tlast(s_tlast),
        .axis_m_tvalid(m_tvalid2), .axis_m_tdata(m_tdata2),
        .axis_m_tready(m_tready), .axis_m_tlast(m_tlast2),
        .pkt_count(cnt2)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) m_tready = ~m_tready;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (chk_stable && stall_v) begin
                chk("stall_valid", {31'b0, m_tvalid0}, 1);
                chk("stall_beat", {23'b0, m_tlast0, m_tdata0},
                    {23'b0, stall_beat});
            end
            if (m_tvalid0 && m_tready) q0.push_back({m_tlast0, m_tdata0});
            if (m_tvalid1 && m_tready) q1.push_back({m_tlast1, m_tdata1});
            stall_v    = m_tvalid0 && !m_tready;
            stall_beat = {m_tlast0, m_tdata0};
        end else begin
            stall_v = 0;
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        s_tvalid = 1;
        s_tdata  = d;
        s_tlast  = l;
        forever begin
            @(negedge clk);
            if (s_tready0) break;
            n++;
            if (n > 60) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        align();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (!m_tvalid0 && !m_tvalid1) break;
            n++;
            if (n > 60) begin
                chk("idle_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic chk_q(input string tag, input logic [8:0] exp0[],
                         input logic [8:0] exp1[]);
        chk({tag, "_len0"}, q0.size(), exp0.size());
        chk({tag, "_len1"}, q1.size(), exp1.size());
        for (int i = 0; i < exp0.size() && i < q0.size(); i++)
            chk($sformatf("%s_e%0d", tag, i), {23'b0, q0[i]},
                {23'b0, exp0[i]});
        for (int i = 0; i < exp1.size() && i < q1.size(); i++)
            chk($sformatf("%s_o%0d", tag, i), {23'b0, q1[i]},
                {23'b0, exp1[i]});
        q0.delete();
        q1.delete();
    endtask

    initial begin
        logic [1:0] wrap_exp[5];
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rst_n    = 0;
        s_tvalid = 0;
        s_tdata  = 8'h00;
        s_tlast  = 0;
        m_tready = 1;
        repeat (3) @(posedge clk);
        #3;
        chk("rst_mvalid", {31'b0, m_tvalid0}, 0);
        chk("rst_mdata", {24'b0, m_tdata0}, 0);
        chk("rst_mlast", {31'b0, m_tlast0}, 0);
        chk("rst_cnt", {16'b0, cnt0}, 0);
        rst_n = 1;
        align();

        // 03,01 -> parity 01 (even) / 00 (odd)
        send_byte(8'h03, 0);
        send_byte(8'h01, 1);
        s_tvalid = 0;
        wait_idle();
        chk_q("p1", '{9'h003, 9'h001, 9'h101}, '{9'h003, 9'h001, 9'h100});
        chk("p1_cnt0", {16'b0, cnt0}, 1);
        chk("p1_cnt1", {16'b0, cnt1}, 1);
        align();

        // AB,54 -> parity 00 / 01
        send_byte(8'hAB, 0);
        send_byte(8'h54, 1);
        s_tvalid = 0;
        wait_idle();
        chk_q("p2", '{9'h0AB, 9'h054, 9'h100}, '{9'h0AB, 9'h054, 9'h101});
        chk("p2_cnt0", {16'b0, cnt0}, 2);
        align();

        // back-to-back single-byte packets
        s_tvalid = 1;
        s_tdata  = 8'h80;
        s_tlast  = 1;
        @(negedge clk);
        chk("b2b_rdy0", {31'b0, s_tready0}, 1);
        align();
        s_tdata = 8'h00;
        @(negedge clk);
        chk("b2b_rdy_par", {31'b0, s_tready0}, 0);
        align();
        @(negedge clk);
        chk("b2b_rdy1", {31'b0, s_tready0}, 1);
        align();
        s_tvalid = 0;
        @(negedge clk);
        chk("b2b_rdy_par2", {31'b0, s_tready0}, 0);
        wait_idle();
        chk_q("p3", '{9'h080, 9'h101, 9'h000, 9'h100},
              '{9'h080, 9'h100, 9'h000, 9'h101});
        chk("p3_cnt0", {16'b0, cnt0}, 4);
        align();

        // toggling backpressure
        m_tready   = 0;
        toggle_en  = 1;
        chk_stable = 1;
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 1);
        s_tvalid = 0;
        wait_idle();
        toggle_en  = 0;
        chk_stable = 0;
        align();
        m_tready = 1;
        chk_q("p4", '{9'h011, 9'h022, 9'h033, 9'h044, 9'h100},
              '{9'h011, 9'h022, 9'h033, 9'h044, 9'h101});
        chk("p4_cnt0", {16'b0, cnt0}, 5);

        // reset mid-packet
        send_byte(8'h0F, 0);
        send_byte(8'h01, 0);
        s_tvalid = 0;
        #2;
        rst_n = 0;
        #1;
        chk("mid_rst_mvalid", {31'b0, m_tvalid0}, 0);
        chk("mid_rst_cnt", {16'b0, cnt0}, 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1;
        align();
        q0.delete();
        q1.delete();
        send_byte(8'h07, 1);
        s_tvalid = 0;
        wait_idle();
        chk_q("p5", '{9'h007, 9'h101}, '{9'h007, 9'h100});
        chk("p5_cnt0", {16'b0, cnt0}, 1);
        align();

        // narrow counter wrap
        rst_n = 0;
        #3;
        rst_n = 1;
        align();
        for (int i = 0; i < 5; i++) begin
            send_byte(8'h01, 1);
            s_tvalid = 0;
            wait_idle();
            chk($sformatf("wrap%0d", i), {30'b0, cnt2},
                {30'b0, wrap_exp[i]});
            align();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
